// File: rtl/sik_stack_file_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sik_stack_file_if : op / flush / response bundle between decode, stack file, execute
// Rev 1.0
// ----------------------------------------------------------------------------
interface sik_stack_file_if #(
  parameter int WIDTH = 16,
  parameter int SPW   = 8,
  parameter int TIDW  = 1
);
  logic             op_valid;
  logic             op_ready;
  logic [TIDW-1:0]  op_tid;
  logic [2:0]       op_code;
  logic [WIDTH-1:0] op_data;
  logic [SPW-1:0]   op_off;
  logic             flush_valid;
  logic [TIDW-1:0]  flush_tid;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [TIDW-1:0]  rsp_tid;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_err;

  modport master (
    output op_valid, op_tid, op_code, op_data, op_off, flush_valid, flush_tid, rsp_ready,
    input  op_ready, rsp_valid, rsp_tid, rsp_data, rsp_err
  );

  modport slave (
    input  op_valid, op_tid, op_code, op_data, op_off, flush_valid, flush_tid, rsp_ready,
    output op_ready, rsp_valid, rsp_tid, rsp_data, rsp_err
  );
endinterface
`default_nettype wire

// File: rtl/sik_stack_file.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sik_stack_file : THREADS independent LIFO operand stacks, one op per cycle, registered response.
// Optional occupancy guard: SIK_STACK_GUARD_EN.                        Rev 1.0
// ----------------------------------------------------------------------------
module sik_stack_file #(
  parameter int WIDTH   = 16,
  parameter int DEPTH   = 256,
  parameter int THREADS = 2,
  parameter int SPW     = 8,
  parameter int TIDW    = 1
) (
  input  logic            clk,
  input  logic            reset,
  sik_stack_file_if.slave bus
);

  localparam int ENTRIES = THREADS * DEPTH;
  localparam int AW      = TIDW + SPW;

  localparam logic [2:0] C_OP_NOP  = 3'd0;
  localparam logic [2:0] C_OP_PUSH = 3'd1;
  localparam logic [2:0] C_OP_POP  = 3'd2;
  localparam logic [2:0] C_OP_PEEK = 3'd3;
  localparam logic [2:0] C_OP_GET  = 3'd4;
  localparam logic [2:0] C_OP_PUT  = 3'd5;
  localparam logic [2:0] C_OP_DUP  = 3'd6;
  localparam logic [2:0] C_OP_SWAP = 3'd7;

  logic [WIDTH-1:0] mem_q [ENTRIES];
  logic [SPW-1:0]   sp_q  [THREADS];
  logic [SPW-1:0]   sp_d  [THREADS];

  logic             rsp_valid_q, rsp_valid_d;
  logic [TIDW-1:0]  rsp_tid_q, rsp_tid_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;

  logic             op_ready;
  logic             accept;
  logic             fault;
  logic             responds;
  logic [WIDTH-1:0] rsp_word;
  logic [SPW-1:0]   sp_cur, sp_inc, sp_dec, sp_off;
  logic [AW-1:0]    top_addr, off_addr;
  logic [WIDTH-1:0] top_data, off_data;
  logic             mem_we;
  logic [AW-1:0]    mem_waddr;
  logic [WIDTH-1:0] mem_wdata;

  // A pending unconsumed response or a flush of the same thread blocks new ops.
  assign op_ready     = !(rsp_valid_q && !bus.rsp_ready) &&
                        !(bus.flush_valid && (bus.flush_tid == bus.op_tid));
  assign bus.op_ready = op_ready;
  // Holding off accept during reset keeps any write from landing while reset is high.
  assign accept       = bus.op_valid && op_ready && !reset;

  assign sp_cur   = sp_q[bus.op_tid];
  assign sp_inc   = sp_cur + SPW'(1);
  assign sp_dec   = sp_cur - SPW'(1);
  assign sp_off   = sp_cur - bus.op_off;
  assign top_addr = {bus.op_tid, sp_cur};
  assign off_addr = {bus.op_tid, sp_off};
  assign top_data = mem_q[top_addr];
  assign off_data = mem_q[off_addr];

`ifdef SIK_STACK_GUARD_EN
  localparam logic [SPW:0] C_FULL = (SPW+1)'(DEPTH);

  logic [SPW:0] cnt_q [THREADS];
  logic [SPW:0] cnt_d [THREADS];
  logic [SPW:0] cnt_cur;
  logic         cnt_full, cnt_empty, off_oob;
  logic         rsp_err_q, rsp_err_d;

  assign cnt_cur   = cnt_q[bus.op_tid];
  assign cnt_full  = (cnt_cur == C_FULL);
  assign cnt_empty = (cnt_cur == '0);
  assign off_oob   = ({1'b0, bus.op_off} >= cnt_cur);

  always_comb begin
    fault = 1'b0;
    case (bus.op_code)
      C_OP_PUSH:                     fault = cnt_full;
      C_OP_POP, C_OP_PEEK, C_OP_SWAP: fault = cnt_empty;
      C_OP_DUP:                      fault = cnt_full || cnt_empty;
      C_OP_GET, C_OP_PUT:            fault = off_oob;
      default:                       fault = 1'b0;
    endcase
  end

  always_comb begin
    for (int t = 0; t < THREADS; t++) cnt_d[t] = cnt_q[t];
    if (accept && !fault) begin
      case (bus.op_code)
        C_OP_PUSH, C_OP_DUP: cnt_d[bus.op_tid] = cnt_cur + (SPW+1)'(1);
        C_OP_POP:            cnt_d[bus.op_tid] = cnt_cur - (SPW+1)'(1);
        default:             ;
      endcase
    end
    if (bus.flush_valid) cnt_d[bus.flush_tid] = '0;
  end

  always_comb begin
    rsp_err_d = rsp_err_q;
    if (responds) rsp_err_d = fault;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int t = 0; t < THREADS; t++) cnt_q[t] <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      for (int t = 0; t < THREADS; t++) cnt_q[t] <= cnt_d[t];
      rsp_err_q <= rsp_err_d;
    end
  end

  assign bus.rsp_err = rsp_err_q;
`else
  assign fault       = 1'b0;
  assign bus.rsp_err = 1'b0;
`endif

  always_comb begin
    for (int t = 0; t < THREADS; t++) sp_d[t] = sp_q[t];
    responds  = 1'b0;
    rsp_word  = '0;
    mem_we    = 1'b0;
    mem_waddr = {bus.op_tid, sp_inc};
    mem_wdata = bus.op_data;
    if (accept && !fault) begin
      case (bus.op_code)
        C_OP_NOP: ;
        C_OP_PUSH: begin
          sp_d[bus.op_tid] = sp_inc;
          mem_we           = 1'b1;
        end
        C_OP_POP: begin
          sp_d[bus.op_tid] = sp_dec;
          responds         = 1'b1;
          rsp_word         = top_data;
        end
        C_OP_PEEK: begin
          responds = 1'b1;
          rsp_word = top_data;
        end
        C_OP_GET: begin
          responds = 1'b1;
          rsp_word = off_data;
        end
        C_OP_PUT: begin
          mem_we    = 1'b1;
          mem_waddr = off_addr;
        end
        C_OP_DUP: begin
          sp_d[bus.op_tid] = sp_inc;
          mem_we           = 1'b1;
          mem_wdata        = top_data;
        end
        C_OP_SWAP: begin
          responds  = 1'b1;
          rsp_word  = top_data;
          mem_we    = 1'b1;
          mem_waddr = top_addr;
        end
        default: ;
      endcase
    end else if (accept) begin
      // Faulted ops always answer, with a zero data word.
      responds = 1'b1;
    end
    if (bus.flush_valid) sp_d[bus.flush_tid] = '1;
  end

  always_comb begin
    rsp_valid_d = rsp_valid_q && !bus.rsp_ready;
    rsp_tid_d   = rsp_tid_q;
    rsp_data_d  = rsp_data_q;
    if (responds) begin
      rsp_valid_d = 1'b1;
      rsp_tid_d   = bus.op_tid;
      rsp_data_d  = rsp_word;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int t = 0; t < THREADS; t++) sp_q[t] <= '1;
      rsp_valid_q <= 1'b0;
      rsp_tid_q   <= '0;
      rsp_data_q  <= '0;
    end else begin
      for (int t = 0; t < THREADS; t++) sp_q[t] <= sp_d[t];
      rsp_valid_q <= rsp_valid_d;
      rsp_tid_q   <= rsp_tid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_tid   = rsp_tid_q;
  assign bus.rsp_data  = rsp_data_q;

endmodule
`default_nettype wire

// File: tb/tb_sik_stack_file.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_sik_stack_file : directed + random ops against queue-based stack model, scoreboard monitor.
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_sik_stack_file;
  localparam int WIDTH = 16, DEPTH = 256, THREADS = 2, SPW = 8, TIDW = 1;
  localparam int NOP = 0, PUSH = 1, POP = 2, PEEK = 3, GET = 4, PUT = 5, DUP = 6, SWAP = 7;

  typedef struct {
    int          tid;
    logic [15:0] data;
    bit          err;
    bit          chk;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sik_stack_file_if #(.WIDTH(WIDTH), .SPW(SPW), .TIDW(TIDW)) bus ();

  sik_stack_file #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .THREADS(THREADS), .SPW(SPW), .TIDW(TIDW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  exp_t        sb[$];
  logic [15:0] st0[$];
  logic [15:0] st1[$];
  int          n_chk = 0, n_pass = 0, cyc = 0;
  bit          rr = 1'b0;
  bit          held = 1'b0;
  logic [15:0] h_data;
  logic        h_tid, h_err;
  exp_t        m_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string name, input longint act, input longint req);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
  endtask

  task automatic model_flush(input int t);
    if (t == 0) st0.delete(); else st1.delete();
  endtask

  // Reference: each thread is a plain queue whose back is the top of stack.
  task automatic model_op(input int tid, input int code, input logic [15:0] d, input int off, input int rcyc);
    logic [15:0] s[$];
    exp_t e;
    int   n;
    bit   under, full;
    s = (tid == 1) ? st1 : st0;
    n = s.size();
    e.tid = tid; e.data = '0; e.err = 1'b0; e.chk = 1'b1; e.cyc = rcyc;
    under = ((code inside {POP, PEEK, SWAP, DUP}) && n == 0) || ((code inside {GET, PUT}) && off >= n);
    full  = (code inside {PUSH, DUP}) && n >= DEPTH;
`ifdef SIK_STACK_GUARD_EN
    if (under || full) begin
      e.err = 1'b1;
      sb.push_back(e);
      return;
    end
`else
    if (under) begin
      e.chk = 1'b0;
      if (code inside {POP, PEEK, GET, SWAP}) sb.push_back(e);
      return;
    end
`endif
    case (code)
      PUSH: s.push_back(d);
      POP:  begin e.data = s[n-1]; void'(s.pop_back()); sb.push_back(e); end
      PEEK: begin e.data = s[n-1]; sb.push_back(e); end
      GET:  begin e.data = s[n-1-off]; sb.push_back(e); end
      PUT:  s[n-1-off] = d;
      DUP:  s.push_back(s[n-1]);
      SWAP: begin e.data = s[n-1]; s[n-1] = d; sb.push_back(e); end
      default: ;
    endcase
    if (tid == 1) st1 = s; else st0 = s;
  endtask

  task automatic do_op(input int tid, input int code, input logic [15:0] d, input int off,
                       input bit fl, input int ft, output int waits);
    bit acc;
    acc = 1'b0;
    waits = 0;
    bus.op_valid = 1'b1; bus.op_tid = 1'(tid); bus.op_code = 3'(code);
    bus.op_data = d; bus.op_off = 8'(off);
    bus.flush_valid = fl; bus.flush_tid = 1'(ft);
    while (!acc && waits < 100) begin
      @(negedge clk);
      acc = bus.op_ready;
      if (bus.flush_valid) model_flush(int'(bus.flush_tid));
      if (acc) model_op(tid, code, d, off, cyc + 1);
      @(posedge clk); #1;
      bus.flush_valid = 1'b0;
      if (rr) bus.rsp_ready = ($urandom_range(0, 3) != 0);
      if (!acc) waits++;
    end
    if (!acc) chk(1'b0, "op_timeout", waits, 0);
    bus.op_valid = 1'b0;
  endtask

  // Scoreboard monitor: checks latency on first appearance, stability while held, content on handshake.
  always @(negedge clk) begin
    if (reset) begin
      held = 1'b0;
    end else if (bus.rsp_valid) begin
      if (held) begin
        chk(bus.rsp_data == h_data && bus.rsp_tid == h_tid && bus.rsp_err == h_err,
            "rsp_hold", {bus.rsp_tid, bus.rsp_err, bus.rsp_data}, {h_tid, h_err, h_data});
      end else if (sb.size() == 0) begin
        chk(1'b0, "unexpected_rsp", bus.rsp_data, 0);
      end else begin
        chk(cyc == sb[0].cyc, "rsp_latency", cyc, sb[0].cyc);
      end
      if (bus.rsp_ready && sb.size() > 0) begin
        m_e = sb.pop_front();
        chk(int'(bus.rsp_tid) == m_e.tid, "rsp_tid", bus.rsp_tid, m_e.tid);
        if (m_e.chk) chk(bus.rsp_data == m_e.data, "rsp_data", bus.rsp_data, m_e.data);
        chk(bus.rsp_err == m_e.err, "rsp_err", bus.rsp_err, m_e.err);
      end
      held = !bus.rsp_ready;
      h_data = bus.rsp_data; h_tid = bus.rsp_tid; h_err = bus.rsp_err;
    end else begin
      held = 1'b0;
      if (sb.size() > 0 && sb[0].cyc < cyc) begin
        chk(1'b0, "missing_rsp", 0, sb[0].data);
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got %0d checks, expected completion", n_chk);
    $fatal(1);
  end

  initial begin
    int w;
    reset = 1'b1;
    bus.op_valid = 0; bus.op_tid = 0; bus.op_code = 0; bus.op_data = 0; bus.op_off = 0;
    bus.flush_valid = 0; bus.flush_tid = 0; bus.rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk(bus.rsp_valid == 1'b0, "reset_rsp_valid", bus.rsp_valid, 0);
    chk(bus.rsp_data == 16'h0, "reset_rsp_data", bus.rsp_data, 0);
    chk(bus.rsp_tid == 1'b0, "reset_rsp_tid", bus.rsp_tid, 0);
    chk(bus.rsp_err == 1'b0, "reset_rsp_err", bus.rsp_err, 0);
    chk(bus.op_ready == 1'b1, "reset_op_ready", bus.op_ready, 1);
    @(posedge clk); #1 reset = 1'b0;

    do_op(0, PUSH, 16'h1234, 0, 0, 0, w);
    do_op(0, PUSH, 16'hBEEF, 0, 0, 0, w);
    do_op(0, POP,  16'h0,    0, 0, 0, w);
    do_op(0, POP,  16'h0,    0, 0, 0, w);

    do_op(0, PUSH, 16'h0001, 0, 0, 0, w);
    do_op(1, PUSH, 16'h0002, 0, 0, 0, w);
    do_op(0, PEEK, 16'h0,    0, 0, 0, w);
    do_op(1, PEEK, 16'h0,    0, 0, 0, w);

    do_op(1, PUSH, 16'h000A, 0, 0, 0, w);
    do_op(1, PUSH, 16'h000B, 0, 0, 0, w);
    do_op(1, PUSH, 16'h000C, 0, 0, 0, w);
    do_op(1, GET,  16'h0,    2, 0, 0, w);
    do_op(1, PUT,  16'h00FF, 1, 0, 0, w);
    do_op(1, POP,  16'h0,    0, 0, 0, w);
    do_op(1, POP,  16'h0,    0, 0, 0, w);

    // Backpressure: response held 3 cycles, op offered meanwhile must stall.
    do_op(0, NOP, 16'h0, 0, 0, 0, w);
    bus.rsp_ready = 1'b0;
    do_op(0, POP, 16'h0, 0, 0, 0, w);
    bus.op_valid = 1'b1; bus.op_tid = 1'b1; bus.op_code = 3'(PEEK);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk(bus.op_ready == 1'b0, "bp_op_ready", bus.op_ready, 0);
      @(posedge clk); #1;
    end
    bus.rsp_ready = 1'b1;
    do_op(1, PEEK, 16'h0, 0, 0, 0, w);
    chk(w == 0, "bp_release_wait", w, 0);

    do_op(0, PUSH, 16'h0005, 0, 0, 0, w);
    do_op(0, PEEK, 16'h0, 0, 1, 0, w);
    chk(w == 1, "flush_stall_wait", w, 1);

    // Overflow by one: guard faults the last push, otherwise sp wraps to 0.
    for (int i = 0; i <= DEPTH; i++) do_op(0, PUSH, 16'(i * 7 + 3), 0, 0, 0, w);
    do_op(0, PEEK, 16'h0, 0, 0, 0, w);
    do_op(0, POP,  16'h0, 0, 0, 0, w);
    do_op(0, NOP,  16'h0, 0, 1, 0, w);
`ifdef SIK_STACK_GUARD_EN
    do_op(0, POP,  16'h0, 0, 0, 0, w);
    do_op(0, PUSH, 16'h0077, 0, 0, 0, w);
    do_op(0, GET,  16'h0, 1, 0, 0, w);
    do_op(0, POP,  16'h0, 0, 0, 0, w);
`endif

    // Reset while a response is pending drops it and empties all stacks.
    do_op(1, PUSH, 16'h0033, 0, 0, 0, w);
    bus.rsp_ready = 1'b0;
    do_op(1, POP, 16'h0, 0, 0, 0, w);
    #2 reset = 1'b1;
    #1;
    chk(bus.rsp_valid == 1'b0, "async_reset_valid", bus.rsp_valid, 0);
    chk(bus.rsp_data == 16'h0, "async_reset_data", bus.rsp_data, 0);
    sb.delete(); st0.delete(); st1.delete();
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
`ifdef SIK_STACK_GUARD_EN
    do_op(1, POP, 16'h0, 0, 0, 0, w);
`endif

    rr = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      int tid, code, off, n, ft;
      bit fl, raw;
      logic [15:0] d;
      tid  = $urandom_range(0, 1);
      n    = (tid == 1) ? st1.size() : st0.size();
      code = $urandom_range(0, 7);
      d    = 16'($urandom);
      off  = 0;
      raw  = 1'b0;
`ifdef SIK_STACK_GUARD_EN
      raw  = ($urandom_range(0, 6) == 0);
`endif
      if (raw) begin
        off = $urandom_range(0, 7);
      end else begin
        if (n == 0 && (code inside {POP, PEEK, GET, PUT, DUP, SWAP})) code = PUSH;
        if (n >= DEPTH - 2 && (code inside {PUSH, DUP})) code = POP;
        if (code inside {GET, PUT}) off = $urandom_range(0, n - 1);
      end
      fl = ($urandom_range(0, 19) == 0);
      ft = 1 - tid;
      do_op(tid, code, d, off, fl, ft, w);
    end

    rr = 1'b0;
    bus.rsp_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk(sb.size() == 0, "drain_outstanding", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
`default_nettype wire
